// File: rtl/fft_mag_scan.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag_scan
// Purpose  : Walks the 8 bins of an upstream 8-point FFT through its select
//            input. For each bin it waits a settle time, then computes the
//            magnitude estimate max(|re|,|im|) + min(|re|,|im|)/2. Each result
//            is handed downstream over a valid/ready port.
//            Optional macro PEAK_DETECT_EN adds tracking of the strongest bin
//            in each scan (peak_bin / peak_mag). Without it, both read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module fft_mag_scan #(
    parameter int SETTLE = 1,
    parameter int MAG_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [2:0]          sel,
    input  logic signed [8:0]   yr,
    input  logic signed [8:0]   yi,
    output logic [MAG_W-1:0]    mag_out,
    output logic [2:0]          bin_idx,
    output logic                mag_valid,
    input  logic                mag_ready,
    output logic                busy,
    output logic                done,
    output logic [2:0]          peak_bin,
    output logic [MAG_W-1:0]    peak_mag
);

    localparam logic [2:0] c_SETTLE_INIT = 3'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUT     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    // Low only in the first cycle after reset release, so a start coincident
    // with the release edge is not taken.
    logic       r_armed;

    // Absolute values are formed at 10 bits so that -256 maps to +256.
    logic [9:0]       w_ext_r;
    logic [9:0]       w_ext_i;
    logic [9:0]       w_abs_r;
    logic [9:0]       w_abs_i;
    logic [9:0]       w_max;
    logic [9:0]       w_min;
    logic [MAG_W-1:0] w_mag;

    assign w_ext_r = {yr[8], yr};
    assign w_ext_i = {yi[8], yi};
    assign w_abs_r = yr[8] ? (~w_ext_r + 10'd1) : w_ext_r;
    assign w_abs_i = yi[8] ? (~w_ext_i + 10'd1) : w_ext_i;
    assign w_max   = (w_abs_r >= w_abs_i) ? w_abs_r : w_abs_i;
    assign w_min   = (w_abs_r >= w_abs_i) ? w_abs_i : w_abs_r;
    // The largest result is 256 + 128 = 384, so 10 bits always hold it.
    assign w_mag   = MAG_W'(w_max + (w_min >> 1));

    // Scan controller: sequences bins and owns every registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_armed   <= 1'b0;
            sel       <= 3'd0;
            mag_out   <= '0;
            bin_idx   <= 3'd0;
            mag_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    sel <= 3'd0;
                    if (start && r_armed) begin
                        r_cnt   <= c_SETTLE_INIT;
                        busy    <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_CAPTURE: begin
                    mag_out   <= w_mag;
                    bin_idx   <= sel;
                    mag_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (mag_ready) begin
                        mag_valid <= 1'b0;
                        if (sel == 3'd7) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            sel     <= sel + 3'd1;
                            r_cnt   <= c_SETTLE_INIT;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    sel     <= 3'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PEAK_DETECT_EN
    logic [2:0]       r_run_bin;
    logic [MAG_W-1:0] r_run_mag;

    // Keep the running maximum (bin 0 seeds it, strict > keeps the lowest
    // index on ties) and publish it on the final transfer of the scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_bin <= 3'd0;
            r_run_mag <= '0;
            peak_bin  <= 3'd0;
            peak_mag  <= '0;
        end else begin
            if (r_state == S_CAPTURE && (sel == 3'd0 || w_mag > r_run_mag)) begin
                r_run_bin <= sel;
                r_run_mag <= w_mag;
            end
            if (r_state == S_OUT && mag_ready && sel == 3'd7) begin
                peak_bin <= r_run_bin;
                peak_mag <= r_run_mag;
            end
        end
    end
`else
    assign peak_bin = 3'd0;
    assign peak_mag = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft_mag_scan
// Purpose  : Directed self-checking bench for fft_mag_scan. A per-bin table
//            stands in for the upstream FFT and is indexed by sel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_mag_scan;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mag_ready;
    logic [2:0]        sel;
    logic [2:0]        bin_idx;
    logic [2:0]        peak_bin;
    logic signed [8:0] yr;
    logic signed [8:0] yi;
    logic [9:0]        mag_out;
    logic [9:0]        peak_mag;
    logic              mag_valid;
    logic              busy;
    logic              done;

    logic signed [8:0] t_yr [8];
    logic signed [8:0] t_yi [8];
    int                exp_mag [8];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign yr = t_yr[sel];
    assign yi = t_yi[sel];

    fft_mag_scan #(.SETTLE(1), .MAG_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (sel),
        .yr        (yr),
        .yi        (yi),
        .mag_out   (mag_out),
        .bin_idx   (bin_idx),
        .mag_valid (mag_valid),
        .mag_ready (mag_ready),
        .busy      (busy),
        .done      (done),
        .peak_bin  (peak_bin),
        .peak_mag  (peak_mag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_bin(input int b, input int r, input int i, input int m);
        t_yr[b]    = 9'(r);
        t_yi[b]    = 9'(i);
        exp_mag[b] = m;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'(sel), 0);
        check({tag, "_mag"},   32'(mag_out), 0);
        check({tag, "_bin"},   32'(bin_idx), 0);
        check({tag, "_valid"}, 32'(mag_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_pbin"},  32'(peak_bin), 0);
        check({tag, "_pmag"},  32'(peak_mag), 0);
    endtask

    // k counts rising edges after the edge that accepts start.
    task automatic run_scan(input int hold_bin, input int hold_cyc,
                            input int mid_start_k, input int abort_bin);
        int k;
        int nxt;
        int held;
        bit got_done;
        bit aborted;
        k = 0; nxt = 0; held = 0; got_done = 0; aborted = 0;
        mag_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        while (k < 300 && !got_done && !aborted) begin
            if (mag_valid) begin
                if (abort_bin == int'(bin_idx)) begin
                    rst = 1'b1;
                    #1;
                    check_all_zero("abort");
                    aborted = 1;
                end else if (hold_bin == int'(bin_idx) && held < hold_cyc) begin
                    mag_ready = 1'b0;
                    held++;
                    check("hold_sel", 32'(sel), 32'(hold_bin));
                    check("hold_bin", 32'(bin_idx), 32'(hold_bin));
                    check("hold_mag", 32'(mag_out), 32'(exp_mag[hold_bin]));
                end else begin
                    mag_ready = 1'b1;
                    if (nxt < 8) begin
                        check("bin_idx", 32'(bin_idx), 32'(nxt));
                        check("mag_out", 32'(mag_out), 32'(exp_mag[nxt]));
                    end else begin
                        check("extra_bin", 32'(nxt), 7);
                    end
                    nxt++;
                end
            end
            if (!aborted && done) begin
                got_done = 1;
                check("done_cycle", 32'(k), 32'(24 + hold_cyc));
                check("bins_seen", 32'(nxt), 8);
                check("busy_in_done", 32'(busy), 0);
            end
            if (!aborted) begin
                start = (k == mid_start_k);
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        mag_ready = 1'b1;
        if (aborted) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("no_done_in_rst", 32'(done), 0);
            end
            // Start coinciding with the release edge must be dropped.
            rst = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_at_release", 32'(busy), 0);
            @(negedge clk);
            check("idle_after_release", 32'(busy), 0);
        end else if (!got_done) begin
            check("scan_timeout", 0, 1);
        end else begin
            check("done_one_cycle", 32'(done), 0);
            check("idle_sel", 32'(sel), 0);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        for (int b = 0; b < 8; b++) set_bin(b, 0, 0, 0);
        rst = 1'b1; start = 1'b0; mag_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 0);
        @(negedge clk);

        // All bins 100 - 40j : 100 + 40/2 = 120
        for (int b = 0; b < 8; b++) set_bin(b, 100, -40, 120);
        run_scan(-1, 0, -1, -1);

        // Full negative scale: 256 + 128 = 384
        for (int b = 0; b < 8; b++) set_bin(b, -256, -256, 384);
        run_scan(-1, 0, -1, -1);

        // Distinct per-bin values, stall 5 cycles at bin 3
        set_bin(0,    0,    0,   0);
        set_bin(1,   -1,    1,   1);
        set_bin(2,  255, -256, 383);
        set_bin(3,   -7,   20,  23);
        set_bin(4,   33,  -33,  49);
        set_bin(5, -100,    3, 101);
        set_bin(6,   10, -255, 260);
        set_bin(7, -128,   64, 160);
        run_scan(3, 5, -1, -1);

        // Start pulsed while busy is ignored
        run_scan(-1, 0, 7, -1);

        // Reset during bin 5 OUT, then a fresh scan from bin 0
        run_scan(-1, 0, -1, 5);
        run_scan(-1, 0, -1, -1);

        // Bins 2 and 6 tie at 200, others 50
        for (int b = 0; b < 8; b++) set_bin(b, 50, 0, 50);
        set_bin(2, 200, 0, 200);
        set_bin(6, 0, -200, 200);
        run_scan(-1, 0, -1, -1);
`ifdef PEAK_DETECT_EN
        check("peak_bin", 32'(peak_bin), 2);
        check("peak_mag", 32'(peak_mag), 200);
`else
        check("peak_bin_off", 32'(peak_bin), 0);
        check("peak_mag_off", 32'(peak_mag), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
